// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB stage vs. queued auxiliary writes.
// Optional WBARB_SCOREBOARD_EN adds rs1/rs2 hazard lookup into the queue.
module wb_port_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 8,
    parameter int CNT_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  logic [4:0]               pipe_waddr,
    input  logic [31:0]              pipe_wdata,
    input  logic                     aux_valid,
    output logic                     aux_ready,
    input  logic [4:0]               aux_waddr,
    input  logic [31:0]              aux_wdata,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     pipe_stall,
`ifdef WBARB_SCOREBOARD_EN
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    output logic                     pend_hazard,
`endif
    output logic [$clog2(DEPTH):0]   pend_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic [CNT_W-1:0] starve_cnt;

    logic empty;
    logic push;
    logic pop;
    logic pipe_req;
    logic force_drain;

    assign empty       = (count == '0);
    assign pipe_req    = pipe_we && (pipe_waddr != 5'd0);
    assign aux_ready   = !rst && (count < (AW+1)'(DEPTH));
    // x0 writes complete the handshake but never occupy a slot
    assign push        = aux_valid && aux_ready && (aux_waddr != 5'd0);
    assign force_drain = (starve_cnt == LIM) && !empty;
    assign pend_cnt    = count;

    always_comb begin
        rf_we      = 1'b0;
        rf_waddr   = 5'd0;
        rf_wdata   = 32'd0;
        pipe_stall = 1'b0;
        pop        = 1'b0;
        if (!rst) begin
            if (force_drain) begin
                rf_we      = 1'b1;
                rf_waddr   = q_addr[rd_ptr];
                rf_wdata   = q_data[rd_ptr];
                pop        = 1'b1;
                pipe_stall = pipe_req;
            end else if (pipe_req) begin
                rf_we    = 1'b1;
                rf_waddr = pipe_waddr;
                rf_wdata = pipe_wdata;
            end else if (!empty) begin
                rf_we    = 1'b1;
                rf_waddr = q_addr[rd_ptr];
                rf_wdata = q_data[rd_ptr];
                pop      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= aux_waddr;
            q_data[wr_ptr] <= aux_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // head age since it became head; saturates so force holds
            if (pop || empty)
                starve_cnt <= '0;
            else if (starve_cnt != LIM)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

`ifdef WBARB_SCOREBOARD_EN
    function automatic logic hit(input logic [4:0] rs);
        logic          h;
        logic [AW-1:0] off;
        h = 1'b0;
        if (rs != 5'd0) begin
            for (int i = 0; i < DEPTH; i++) begin
                off = AW'(i) - rd_ptr;
                if (({1'b0, off} < count) && (q_addr[i] == rs))
                    h = 1'b1;
            end
            if (push && (aux_waddr == rs))
                h = 1'b1;
        end
        return h;
    endfunction

    assign pend_hazard = hit(rs1) || hit(rs2);
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=4, STARVE_LIM=8).
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_waddr;
    logic [31:0] aux_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pipe_stall;
    logic [2:0]  pend_cnt;
`ifdef WBARB_SCOREBOARD_EN
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        pend_hazard;
`endif

    int errors = 0;
    int checks = 0;

    wb_port_arbiter #(
        .DEPTH(4),
        .STARVE_LIM(8),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pipe_we(pipe_we),
        .pipe_waddr(pipe_waddr),
        .pipe_wdata(pipe_wdata),
        .aux_valid(aux_valid),
        .aux_ready(aux_ready),
        .aux_waddr(aux_waddr),
        .aux_wdata(aux_wdata),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .pipe_stall(pipe_stall),
`ifdef WBARB_SCOREBOARD_EN
        .rs1(rs1),
        .rs2(rs2),
        .pend_hazard(pend_hazard),
`endif
        .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_pipe(input logic we, input logic [4:0] a,
                            input logic [31:0] d);
        pipe_we    = we;
        pipe_waddr = a;
        pipe_wdata = d;
    endtask

    task automatic set_aux(input logic v, input logic [4:0] a,
                           input logic [31:0] d);
        aux_valid = v;
        aux_waddr = a;
        aux_wdata = d;
    endtask

    task automatic test_reset;
        logic [38:0] got;
        logic [38:0] exp;
        for (int i = 0; i < 2; i++) begin
            rst = 1'b1;
            set_pipe(1'b1, 5'd3, 32'h33);
            set_aux(1'b1, 5'd4, 32'h44);
            #1;
            got = {rf_we, aux_ready, pipe_stall, pend_cnt, 33'd0};
            exp = 39'd0;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d got=%h exp=%h",
                         i, got, exp);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        set_pipe(1'b0, 5'd0, 32'd0);
        set_aux(1'b0, 5'd0, 32'd0);
        #1;
        checks++;
        if ({pend_cnt, aux_ready, rf_we} !== {3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_release pend=%0d rdy=%b we=%b",
                     pend_cnt, aux_ready, rf_we);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain;
        set_pipe(1'b1, 5'd1, 32'h1);
        set_aux(1'b1, 5'd4, 32'h40);
        @(negedge clk);
        set_aux(1'b1, 5'd5, 32'h50);
        @(negedge clk);
        set_aux(1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        #1;
        checks++;
        if ({rf_we, pend_cnt} !== {1'b0, 3'd2}) begin
            errors++;
            $display("FAIL mid_rst_in we=%b pend=%0d exp we=0 pend=2",
                     rf_we, pend_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        set_pipe(1'b0, 5'd0, 32'd0);
        #1;
        checks++;
        if ({rf_we, pend_cnt} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL mid_rst_out we=%b pend=%0d exp we=0 pend=0",
                     rf_we, pend_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_aux_idle;
        set_aux(1'b1, 5'd5, 32'h11);
        #1;
        checks++;
        if ({aux_ready, rf_we} !== 2'b10) begin
            errors++;
            $display("FAIL idle_accept rdy=%b we=%b exp rdy=1 we=0",
                     aux_ready, rf_we);
        end
        @(negedge clk);
        set_aux(1'b1, 5'd6, 32'h22);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, pend_cnt}
                !== {1'b1, 5'd5, 32'h11, 3'd1}) begin
            errors++;
            $display("FAIL idle_wr_x5 we=%b a=%0d d=%h pend=%0d",
                     rf_we, rf_waddr, rf_wdata, pend_cnt);
        end
        @(negedge clk);
        set_aux(1'b0, 5'd0, 32'd0);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, pend_cnt}
                !== {1'b1, 5'd6, 32'h22, 3'd1}) begin
            errors++;
            $display("FAIL idle_wr_x6 we=%b a=%0d d=%h pend=%0d",
                     rf_we, rf_waddr, rf_wdata, pend_cnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, pend_cnt}
                !== {1'b0, 5'd0, 32'd0, 3'd0}) begin
            errors++;
            $display("FAIL idle_empty we=%b a=%0d d=%h pend=%0d",
                     rf_we, rf_waddr, rf_wdata, pend_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_starve;
        logic [4:0] a;
        set_pipe(1'b1, 5'd1, 32'h1001);
        set_aux(1'b1, 5'd7, 32'hAB);
        #1;
        checks++;
        if ({rf_we, rf_waddr, pipe_stall} !== {1'b1, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL starve_c0 we=%b a=%0d stall=%b",
                     rf_we, rf_waddr, pipe_stall);
        end
        @(negedge clk);
        set_aux(1'b0, 5'd0, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            a = 5'(k + 1);
            set_pipe(1'b1, a, 32'h1000 + 32'(k + 1));
            #1;
            checks++;
            if ({rf_we, rf_waddr, rf_wdata, pipe_stall, pend_cnt}
                    !== {1'b1, a, 32'h1000 + 32'(k + 1), 1'b0, 3'd1}) begin
                errors++;
                $display("FAIL starve_wait%0d a=%0d d=%h stall=%b pend=%0d",
                         k, rf_waddr, rf_wdata, pipe_stall, pend_cnt);
            end
            @(negedge clk);
        end
        set_pipe(1'b1, 5'd10, 32'h100A);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, pipe_stall}
                !== {1'b1, 5'd7, 32'hAB, 1'b1}) begin
            errors++;
            $display("FAIL starve_force a=%0d d=%h stall=%b exp a=7 d=ab st=1",
                     rf_waddr, rf_wdata, pipe_stall);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, pipe_stall, pend_cnt}
                !== {1'b1, 5'd10, 32'h100A, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL starve_held a=%0d d=%h stall=%b pend=%0d",
                     rf_waddr, rf_wdata, pipe_stall, pend_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_full_wrap;
        logic [4:0]  pa;
        logic [38:0] got;
        logic [38:0] exp;
        logic        exp_rdy;
        logic [2:0]  exp_pend;
        for (int c = 0; c <= 10; c++) begin
            pa = 5'(20 + ((c > 9) ? 9 : c));
            set_pipe(1'b1, pa, 32'h2000 + 32'(pa));
            if (c < 4) set_aux(1'b1, 5'(10 + c), 32'h100 + 32'(c));
            else       set_aux(1'b1, 5'd14, 32'h104);
            exp_rdy  = (c < 4) || (c == 10);
            exp_pend = (c < 4) ? 3'(c) : ((c == 10) ? 3'd3 : 3'd4);
            if (c == 9) exp = {1'b1, 5'd10, 32'h100, 1'b1};
            else        exp = {1'b1, pa, 32'h2000 + 32'(pa), 1'b0};
            #1;
            got = {rf_we, rf_waddr, rf_wdata, pipe_stall};
            checks++;
            if ({got, aux_ready, pend_cnt} !== {exp, exp_rdy, exp_pend}) begin
                errors++;
                $display("FAIL full_c%0d rf=%h rdy=%b pend=%0d exp rf=%h rdy=%b pend=%0d",
                         c, got, aux_ready, pend_cnt, exp, exp_rdy, exp_pend);
            end
            @(negedge clk);
        end
        set_pipe(1'b0, 5'd0, 32'd0);
        set_aux(1'b0, 5'd0, 32'd0);
        for (int j = 0; j < 4; j++) begin
            #1;
            checks++;
            if ({rf_we, rf_waddr, rf_wdata, pend_cnt}
                    !== {1'b1, 5'(11 + j), 32'h101 + 32'(j), 3'(4 - j)}) begin
                errors++;
                $display("FAIL wrap_drain%0d a=%0d d=%h pend=%0d",
                         j, rf_waddr, rf_wdata, pend_cnt);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({rf_we, pend_cnt} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL wrap_empty we=%b pend=%0d", rf_we, pend_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_x0;
        set_pipe(1'b1, 5'd0, 32'hBEEF);
        set_aux(1'b1, 5'd0, 32'hDEAD);
        #1;
        checks++;
        if ({aux_ready, rf_we, pipe_stall} !== 3'b100) begin
            errors++;
            $display("FAIL x0_cycle rdy=%b we=%b stall=%b exp 1 0 0",
                     aux_ready, rf_we, pipe_stall);
        end
        @(negedge clk);
        set_pipe(1'b0, 5'd0, 32'd0);
        set_aux(1'b0, 5'd0, 32'd0);
        #1;
        checks++;
        if ({rf_we, pend_cnt} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL x0_after we=%b pend=%0d", rf_we, pend_cnt);
        end
        @(negedge clk);
    endtask

`ifdef WBARB_SCOREBOARD_EN
    task automatic test_hazard;
        set_pipe(1'b1, 5'd1, 32'h1);
        set_aux(1'b1, 5'd9, 32'h99);
        rs1 = 5'd9;
        rs2 = 5'd0;
        #1;
        checks++;
        if (pend_hazard !== 1'b1) begin
            errors++;
            $display("FAIL haz_accept got=%b exp=1", pend_hazard);
        end
        @(negedge clk);
        set_aux(1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (pend_hazard !== 1'b1) begin
                errors++;
                $display("FAIL haz_queued%0d got=%b exp=1", k, pend_hazard);
            end
            @(negedge clk);
        end
        rs1 = 5'd3;
        #1;
        checks++;
        if (pend_hazard !== 1'b0) begin
            errors++;
            $display("FAIL haz_rs2_zero got=%b exp=0", pend_hazard);
        end
        rs1 = 5'd9;
        set_pipe(1'b0, 5'd0, 32'd0);
        #1;
        checks++;
        if ({rf_we, rf_waddr} !== {1'b1, 5'd9}) begin
            errors++;
            $display("FAIL haz_pop we=%b a=%0d", rf_we, rf_waddr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (pend_hazard !== 1'b0) begin
            errors++;
            $display("FAIL haz_cleared got=%b exp=0", pend_hazard);
        end
        rs1 = 5'd0;
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1;
        set_pipe(1'b0, 5'd0, 32'd0);
        set_aux(1'b0, 5'd0, 32'd0);
`ifdef WBARB_SCOREBOARD_EN
        rs1 = 5'd0;
        rs2 = 5'd0;
`endif
        @(negedge clk);
        test_reset();
        test_reset_mid_drain();
        test_aux_idle();
        test_starve();
        test_full_wrap();
        test_x0();
`ifdef WBARB_SCOREBOARD_EN
        test_hazard();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
